pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
//
// PURPOSE
//   Generic, width-parametrised pipeline stage register with valid/ready handshake and a
//   2-entry skid buffer. Replaces hand-written per-field stage latches: each stage packs
//   its control/data fields into one bus. Gives full throughput with a registered in_ready
//   (no combinational ready path between stages), plus synchronous flush to a bubble value.
//
// PARAMETERS
//   WIDTH    32   payload width in bits (packed stage fields)
//   CLR_VAL  '0   payload value loaded on reset and flush (bubble/NOP encoding)
//   CNT_W    16   perf counter width (used only with PIPE_PERF_EN)
//
// PORTS
//   CLK        in   1      clock, all state on rising edge
//   RST        in   1      asynchronous reset, active-high
//   in_valid   in   1      upstream beat present
//   in_ready   out  1      stage can accept; driven from state register only
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      downstream beat present
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  downstream payload (= main register)
//   flush      in   1      synchronous kill of all held beats
//   occupancy  out  2      beats held: 0, 1 or 2
//   perf_clr   in   1      [PIPE_PERF_EN only] synchronous clear of counters
//   stall_cnt  out  CNT_W  [PIPE_PERF_EN only] cycles with out_valid & !out_ready
//   flush_cnt  out  CNT_W  [PIPE_PERF_EN only] flushes that discarded >=1 beat
//
// BEHAVIOUR
//   - Accept = in_valid & in_ready; emit = out_valid & out_ready.
//   - Storage: main reg (drives out_data), skid reg; FSM EMPTY / ONE / FULL.
//   - in_ready = (state != FULL); out_valid = (state != EMPTY); occupancy = 0/1/2.
//   - EMPTY: accept -> main<=in_data, ONE.
//   - ONE: accept&emit -> main<=in_data, ONE; accept&!emit -> skid<=in_data, FULL;
//          !accept&emit -> EMPTY; else hold.
//   - FULL: emit -> main<=skid, ONE (no accept possible); else hold.
//   - Order strictly FIFO; no beat lost or duplicated.
//   - Latency 1 cycle from accept to out_valid when EMPTY; sustained 1 beat/cycle.
//   - Draining to EMPTY leaves main unchanged; out_data is don't-care while !out_valid.
//   - flush (highest sync priority): state<=EMPTY, main<=CLR_VAL, skid<=CLR_VAL. A beat
//     with in_valid&in_ready in the flush cycle counts as accepted and is discarded. A
//     beat emitted in the flush cycle is delivered (downstream saw the handshake).
//   - RST asserted (any time, incl. mid-transfer): immediately state=EMPTY, main=skid=
//     CLR_VAL, counters=0; so out_valid=0, in_ready=1, occupancy=0, out_data=CLR_VAL.
//     Outputs stay so until first CLK edge after RST deasserts.
//   - in_data/out_ready changes while unaccepted/unemitted are legal; state unchanged.
//
// CONFIGURATION
//   PIPE_PERF_EN defined: perf_clr/stall_cnt/flush_cnt ports and counters present.
//     stall_cnt +1 each cycle out_valid&!out_ready; flush_cnt +1 each flush with
//     occupancy!=0. Both saturate at all-ones; perf_clr zeroes both (wins over increment).
//   PIPE_PERF_EN undefined: those ports and counters absent; datapath identical.
//
// TESTING  (WIDTH=32, CLR_VAL=0, CNT_W=3 unless noted)
//   1 RST=1 mid-stream, FULL -> same cycle out_valid=0, in_ready=1, occupancy=0, out_data=0.
//   2 out_ready=1, in beats 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on three
//     consecutive cycles, first one cycle after accept, in_ready stays 1.
//   3 out_ready=0, send 0xA,0xB -> occupancy=2, in_ready=0, 0xC held; out_ready=1 ->
//     0xA,0xB,0xC emitted in order, each exactly once.
//   4 ONE holding 0x5, flush=1 with in_valid=1 in_data=0x6 -> next cycle occupancy=0,
//     out_valid=0, out_data=0; 0x6 never emitted.
//   5 FULL, flush=1 & out_ready=1 -> main beat emitted this cycle, skid beat dropped,
//     next cycle EMPTY.
//   6 PIPE_PERF_EN: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; 10 cycles -> 7
//     (saturated); perf_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Width-parametrised pipeline stage: valid/ready handshake over a main + skid register pair,
// with a registered in_ready, synchronous flush to CLR_VAL. Optional perf counters under PIPE_PERF_EN.
module pipe_stage_buf #(
    parameter int                 WIDTH   = 32,
    parameter logic [WIDTH-1:0]   CLR_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  out_data_o,
    input  logic              flush_i,
    output logic [1:0]        occupancy_o
`ifdef PIPE_PERF_EN
    ,
    input  logic              perf_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  main_q,  main_d;
    logic [WIDTH-1:0]  skid_q,  skid_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occ_q,       occ_d;
    logic              accept_s;
    logic              emit_s;

    assign accept_s = in_valid_i & in_ready_q;
    assign emit_s   = out_valid_q & out_ready_i;

    // Next-state and storage update; flush overrides every handshake outcome.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = CLR_VAL;
            skid_d  = CLR_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end else if (accept_s) begin
                        skid_d  = in_data_i;
                        state_d = ST_FULL;
                    end else if (emit_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (emit_s) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = CLR_VAL;
                    skid_d  = CLR_VAL;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the next state so they leave straight from flops.
    always_comb begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occ_d       = 2'd0;
        case (state_d)
            ST_EMPTY: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                occ_d       = 2'd0;
            end
            ST_ONE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b1;
                occ_d       = 2'd1;
            end
            ST_FULL: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                occ_d       = 2'd2;
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                occ_d       = 2'd0;
            end
        endcase
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= CLR_VAL;
            skid_q      <= CLR_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = occ_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Counter updates; clear beats increment, and only flushes that discard beats count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (out_valid_q && !out_ready_i) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_i && (state_q != ST_EMPTY)) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
